// File: rtl/allbit_run_monitor.sv
// rtl/allbit_run_monitor.sv - registered masked all-zero/all-one detector with run counters and sticky alarms
module allbit_run_monitor #(
   parameter int WIDTH  = 32,
   parameter int CNT_W  = 8,
   parameter int THRESH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] mask,
   input  logic             clear,
   output logic             out_valid,
   output logic             zero,
   output logic             one,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] zero_run,
   output logic [CNT_W-1:0] one_run,
   output logic             zero_alarm,
   output logic             one_alarm
);

   localparam logic [1:0] ST_MIXED = 2'd0;
   localparam logic [1:0] ST_ZERO  = 2'd1;
   localparam logic [1:0] ST_ONE   = 2'd2;
   localparam logic [1:0] ST_BOTH  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             zero_c;
   logic             one_c;
   logic [CNT_W-1:0] zero_base;
   logic [CNT_W-1:0] one_base;
   logic [CNT_W-1:0] zero_next;
   logic [CNT_W-1:0] one_next;
   logic [1:0]       state_next;

   // An empty mask makes both conditions vacuously true.
   assign zero_c = ~|(x & mask);
   assign one_c  = &(x | ~mask);

   always_comb begin
      // A clear restarts the runs so the word in the same cycle counts as the first of a new run.
      zero_base = clear ? '0 : zero_run;
      one_base  = clear ? '0 : one_run;
      zero_next = '0;
      one_next  = '0;
      if (zero_c) begin
         zero_next = (zero_base == CNT_MAX) ? CNT_MAX : zero_base + CNT_ONE;
      end
      if (one_c) begin
         one_next = (one_base == CNT_MAX) ? CNT_MAX : one_base + CNT_ONE;
      end
      state_next = ST_MIXED;
      if (zero_c && one_c) begin
         state_next = ST_BOTH;
      end else if (zero_c) begin
         state_next = ST_ZERO;
      end else if (one_c) begin
         state_next = ST_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         zero       <= 1'b0;
         one        <= 1'b0;
         state      <= ST_MIXED;
         zero_run   <= '0;
         one_run    <= '0;
         zero_alarm <= 1'b0;
         one_alarm  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            zero       <= zero_c;
            one        <= one_c;
            state      <= state_next;
            zero_run   <= zero_next;
            one_run    <= one_next;
            zero_alarm <= (zero_alarm & ~clear) | (zero_next >= THR);
            one_alarm  <= (one_alarm & ~clear) | (one_next >= THR);
         end else if (clear) begin
            state      <= ST_MIXED;
            zero_run   <= '0;
            one_run    <= '0;
            zero_alarm <= 1'b0;
            one_alarm  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_allbit_run_monitor.sv
// tb/tb_allbit_run_monitor.sv - self-checking bench for allbit_run_monitor
module tb_allbit_run_monitor;

   localparam int WIDTH  = 32;
   localparam int CNT_W  = 4;
   localparam int THRESH = 3;
   localparam int CMAX   = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] mask;
   logic             clear;
   logic             out_valid;
   logic             zero;
   logic             one;
   logic [1:0]       state;
   logic [CNT_W-1:0] zero_run;
   logic [CNT_W-1:0] one_run;
   logic             zero_alarm;
   logic             one_alarm;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   allbit_run_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .mask(mask), .clear(clear),
      .out_valid(out_valid), .zero(zero), .one(one), .state(state),
      .zero_run(zero_run), .one_run(one_run), .zero_alarm(zero_alarm), .one_alarm(one_alarm)
   );

   typedef struct {
      logic        rst, v, clr;
      logic [31:0] xv, mv;
      logic        ov, z, o;
      logic [1:0]  st;
      int          zr, orr;
      logic        za, oa;
   } vec_t;

   vec_t vecs[$];

   // Reference model state, tracked as plain integers.
   int m_ov, m_z, m_o, m_st, m_zr, m_or, m_za, m_oa;

   function automatic vec_t mk(logic rst, logic v, logic clr, logic [31:0] xv, logic [31:0] mv,
                               logic ov, logic z, logic o, logic [1:0] st, int zr, int orr,
                               logic za, logic oa);
      vec_t r;
      r.rst = rst; r.v = v; r.clr = clr; r.xv = xv; r.mv = mv;
      r.ov = ov; r.z = z; r.o = o; r.st = st; r.zr = zr; r.orr = orr; r.za = za; r.oa = oa;
      return r;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_all(input string tag, input int ov, input int z, input int o, input int st,
                            input int zr, input int orr, input int za, input int oa);
      check({tag, ".out_valid"}, int'(out_valid), ov);
      check({tag, ".zero"}, int'(zero), z);
      check({tag, ".one"}, int'(one), o);
      check({tag, ".state"}, int'(state), st);
      check({tag, ".zero_run"}, int'(zero_run), zr);
      check({tag, ".one_run"}, int'(one_run), orr);
      check({tag, ".zero_alarm"}, int'(zero_alarm), za);
      check({tag, ".one_alarm"}, int'(one_alarm), oa);
   endtask

   task automatic apply(input logic rst, input logic v, input logic clr,
                        input logic [31:0] xv, input logic [31:0] mv);
      reset = rst; in_valid = v; clear = clr; x = xv; mask = mv;
      @(posedge clk);
      #1;
   endtask

   task automatic model_step(input logic rst, input logic v, input logic clr,
                             input logic [31:0] xv, input logic [31:0] mv);
      int zc, oc;
      if (rst) begin
         m_ov = 0; m_z = 0; m_o = 0; m_st = 0; m_zr = 0; m_or = 0; m_za = 0; m_oa = 0;
         return;
      end
      m_ov = v;
      if (clr) begin
         m_zr = 0; m_or = 0; m_za = 0; m_oa = 0; m_st = 0;
      end
      if (v) begin
         zc = ((xv & mv) == 32'd0) ? 1 : 0;
         oc = ((xv | ~mv) == 32'hFFFF_FFFF) ? 1 : 0;
         m_z = zc;
         m_o = oc;
         m_st = 2 * oc + zc;
         m_zr = zc ? ((m_zr + 1 > CMAX) ? CMAX : m_zr + 1) : 0;
         m_or = oc ? ((m_or + 1 > CMAX) ? CMAX : m_or + 1) : 0;
         if (m_zr >= THRESH) m_za = 1;
         if (m_or >= THRESH) m_oa = 1;
      end
   endtask

   initial begin
      int k;
      logic [31:0] rx, rm;
      logic rv, rc, rr;
      reset = 1'b1; in_valid = 1'b0; clear = 1'b0; x = '0; mask = '1;

      // reset, zero run, masking, clear
      vecs.push_back(mk(1,1,0,32'h0,32'hFFFFFFFF, 0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,32'h0,32'hFFFFFFFF, 0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,32'h0,32'hFFFFFFFF, 1,1,0,1,1,0,0,0));
      vecs.push_back(mk(0,1,0,32'h0,32'hFFFFFFFF, 1,1,0,1,2,0,0,0));
      vecs.push_back(mk(0,1,0,32'h0,32'hFFFFFFFF, 1,1,0,1,3,0,1,0));
      vecs.push_back(mk(0,1,0,32'h0,32'hFFFFFFFF, 1,1,0,1,4,0,1,0));
      vecs.push_back(mk(0,1,0,32'h12345678,32'hFFFFFFFF, 1,0,0,0,0,0,1,0));
      vecs.push_back(mk(0,1,0,32'hFFFF0000,32'h0000FFFF, 1,1,0,1,1,0,1,0));
      vecs.push_back(mk(0,1,0,32'h1234FFFF,32'h0000FFFF, 1,0,1,2,0,1,1,0));
      vecs.push_back(mk(0,1,0,32'hDEADBEEF,32'h00000000, 1,1,1,3,1,2,1,0));
      vecs.push_back(mk(0,1,0,32'hDEADBEEF,32'h00000000, 1,1,1,3,2,3,1,1));
      vecs.push_back(mk(0,0,0,32'h12345678,32'hFFFFFFFF, 0,1,1,3,2,3,1,1));
      vecs.push_back(mk(0,1,0,32'h0,32'hFFFFFFFF, 1,1,0,1,3,0,1,1));
      vecs.push_back(mk(0,1,0,32'h0,32'hFFFFFFFF, 1,1,0,1,4,0,1,1));
      vecs.push_back(mk(0,1,0,32'h0,32'hFFFFFFFF, 1,1,0,1,5,0,1,1));
      vecs.push_back(mk(0,1,1,32'h0,32'hFFFFFFFF, 1,1,0,1,1,0,0,0));
      vecs.push_back(mk(0,0,1,32'h0,32'hFFFFFFFF, 0,1,0,0,0,0,0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].v, vecs[i].clr, vecs[i].xv, vecs[i].mv);
         check_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].z, vecs[i].o, vecs[i].st,
                   vecs[i].zr, vecs[i].orr, vecs[i].za, vecs[i].oa);
      end

      // saturation through gaps
      apply(1, 0, 0, 32'h0, 32'hFFFFFFFF);
      for (int w = 1; w <= 20; w++) begin
         apply(0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
         check($sformatf("sat%0d.one_run", w), int'(one_run), (w > CMAX) ? CMAX : w);
         check($sformatf("sat%0d.one_alarm", w), int'(one_alarm), (w >= THRESH) ? 1 : 0);
         check($sformatf("sat%0d.zero_run", w), int'(zero_run), 0);
         if (w % 3 == 0) begin
            apply(0, 0, 0, 32'h0, 32'hFFFFFFFF);
            check($sformatf("gap%0d.out_valid", w), int'(out_valid), 0);
            check($sformatf("gap%0d.one_run", w), int'(one_run), (w > CMAX) ? CMAX : w);
         end
      end

      // reset in the middle of a run
      apply(1, 0, 0, 32'h0, 32'hFFFFFFFF);
      for (int w = 0; w < 7; w++) apply(0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("pre_reset.one_run", int'(one_run), 7);
      apply(1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check_all("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("post_reset.one_run", int'(one_run), 1);

      // randomized traffic against the reference model
      apply(1, 0, 0, 32'h0, 32'hFFFFFFFF);
      model_step(1, 0, 0, 32'h0, 32'hFFFFFFFF);
      for (int c = 0; c < 600; c++) begin
         k  = $urandom_range(0, 9);
         rx = (k < 4) ? 32'h0 : (k < 8) ? 32'hFFFFFFFF : $urandom;
         k  = $urandom_range(0, 9);
         rm = (k < 6) ? 32'hFFFFFFFF : (k < 8) ? $urandom : 32'h0;
         if ($urandom_range(0, 9) == 0) rx = rx ^ (32'h1 << $urandom_range(0, 31));
         rv = ($urandom_range(0, 3) != 0);
         rc = ($urandom_range(0, 39) == 0);
         rr = ($urandom_range(0, 149) == 0);
         apply(rr, rv, rc, rx, rm);
         model_step(rr, rv, rc, rx, rm);
         check_all($sformatf("rnd%0d", c), m_ov, m_z, m_o, m_st, m_zr, m_or, m_za, m_oa);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/allbit_run_monitor.md
# allbit_run_monitor

Parametrised, registered successor to the combinational all-zero/all-one detector. Evaluates each accepted word under a per-bit care mask and flags all-zero and all-one. Tracks run lengths of consecutive all-zero and all-one words and raises sticky alarms when a run reaches a threshold. Sits on a valid-qualified data stream as a watchdog for stuck-at buses and idle-pattern detection.

## Interface

Parameters:
- WIDTH, 32, data/mask width in bits (>=1)
- CNT_W, 8, run-counter width in bits (>=2)
- THRESH, 4, run length that sets an alarm (1 <= THRESH <= 2^CNT_W-1)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  word on x/mask is accepted this edge
- x  input  WIDTH  data word
- mask  input  WIDTH  care mask; bit=1 means the bit is checked, bit=0 means don't-care
- clear  input  1  synchronous clear of counters, alarms and state; lower priority than reset
- out_valid  output  1  one-cycle pulse; zero/one/state reflect the word accepted on the previous edge
- zero  output  1  last accepted word: all cared bits are 0
- one  output  1  last accepted word: all cared bits are 1
- state  output  2  run state: 0 MIXED, 1 ZERO, 2 ONE, 3 BOTH
- zero_run  output  CNT_W  consecutive all-zero words accepted, saturating
- one_run  output  CNT_W  consecutive all-one words accepted, saturating
- zero_alarm  output  1  sticky: zero_run has reached THRESH
- one_alarm  output  1  sticky: one_run has reached THRESH

## Operation

- Per-word evaluation:
  - zero_c = ~|(x & mask)
  - one_c = &(x | ~mask)
  - mask all-zero: both are true (vacuous).
- State register, updated only on accepted words:
  - zero_c & one_c -> BOTH
  - zero_c only -> ZERO
  - one_c only -> ONE
  - neither -> MIXED
- zero_run on an accepted word:
  - zero_c=1: increment, saturating at 2^CNT_W-1 and holding there.
  - zero_c=0: load 0.
  - one_run follows the same rule with one_c.
- in_valid=0: counters, state, zero, one and alarms hold. Gaps do not break a run.
- Alarms:
  - zero_alarm sets on the edge where the updated zero_run >= THRESH. It stays set until clear or reset.
  - one_alarm follows the same rule. A broken run does not clear an alarm.
- clear=1:
  - Alarms go to 0 and state goes to MIXED.
  - Counters restart. If in_valid is also high, the word in that cycle is the first word of a new run: each counter loads 1 if its condition holds, else 0. The state reflects that word.
  - Alarms are re-evaluated against the restarted counters, so they set only if THRESH=1.
  - zero/one/out_valid behave as for any accepted word.
- reset=1: overrides in_valid and clear. All registers go to their reset values.

## Timing

- Reset values: out_valid=0, zero=0, one=0, state=0 (MIXED), zero_run=0, one_run=0, zero_alarm=0, one_alarm=0.
- Latency: 1 cycle. A word accepted at edge N has its zero/one/state/run/alarm visible after edge N and out_valid=1 for the cycle following edge N.
- Back-to-back valid words are accepted every cycle. There is no backpressure and no ready signal.
- An alarm asserts in the same cycle as the counter value that reaches THRESH.
- Reset asserted mid-run: the next cycle shows reset values and the run restarts from 0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

All cases use WIDTH=32, CNT_W=4, THRESH=3 and mask=FFFFFFFF unless stated.

1. Reset: hold reset for 2 cycles with in_valid=1, x=0 -> all outputs 0 and out_valid stays 0.
2. Zero run: x=00000000 valid for 4 consecutive cycles:
   - zero_run reads 1,2,3,4 and zero=1, state=1.
   - zero_alarm rises with zero_run=3.
   - Then x=12345678 -> zero=0, one=0, state=0, zero_run=0, zero_alarm still 1.
3. Saturation and gaps: x=FFFFFFFF valid for 20 words with in_valid=0 gaps between some of them -> one_run climbs through the gaps and saturates at 15. one_alarm is set from the third word and zero_run stays 0.
4. Masking:
   - mask=0000FFFF, x=FFFF0000 -> zero=1, one=0.
   - mask=0000FFFF, x=1234FFFF -> one=1, zero=0.
   - mask=00000000, x=DEADBEEF -> zero=1, one=1, state=3 and both counters increment.
5. Clear: with zero_run=5 and zero_alarm=1, assert clear with in_valid=1, x=0 -> zero_run=1, zero_alarm=0, state=1. Clear with in_valid=0 -> zero_run=0, one_run=0, state=0.
6. Reset mid-run: with one_run=7, assert reset for 1 cycle -> next cycle all outputs match reset values. x=FFFFFFFF afterwards -> one_run=1.
